display_leitor: RTL and testbench
=================================

DISPLAY_LEITOR -- requirements
Module: display_leitor

Interface
REQ-001 Parameter ESTAVEL, default 4, is the number of consecutive sampled cycles a segment pattern must hold before it is accepted; legal range 2..15.
REQ-002 clock  input  1  single clock for the block; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
REQ-004 segmentos  input  7  active-low seven-segment pattern, bit 6 = segment a ... bit 0 = segment g.
REQ-005 ativo  input  1  display-enabled qualifier; 0 means the bus is treated as blank.
REQ-006 pronto  input  1  downstream ready.
REQ-007 valido  output  1  output word available.
REQ-008 valor  output  4  decoded digit, 0..10.
REQ-009 erro  output  1  the current output word came from an unrecognised pattern.
REQ-010 sobrecarga  output  1  sticky flag; an accepted word was dropped because the buffer was full.

Function
REQ-011 The decode table SHALL be exact: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001101->7, 0000000->8, 0000100->9, 1111110->10 (minus sign); 1111111 is blank.
REQ-012 segmentos SHALL be registered once per clock into a sample register; all decisions use the sample register only.
REQ-013 A sample with ativo=0 SHALL be treated as the blank pattern.
REQ-014 The FSM SHALL have three states: OCIOSO (blank or cleared), ESTABILIZANDO (non-blank pattern being counted), EMITIDO (pattern accepted, waiting for a change).
REQ-015 A 4-bit stability counter SHALL load 1 on any sample that differs from the previous sample, and increment on an equal sample while in ESTABILIZANDO.
REQ-016 OCIOSO->ESTABILIZANDO SHALL occur on a non-blank sample; any state->OCIOSO SHALL occur on a blank sample.
REQ-017 When the counter reaches ESTAVEL in ESTABILIZANDO, the pattern SHALL be accepted once and the FSM SHALL move to EMITIDO.
REQ-018 In EMITIDO, an unchanged pattern SHALL never be re-accepted; a different non-blank sample SHALL move the FSM to ESTABILIZANDO with counter=1.
REQ-019 An accepted recognised pattern SHALL produce the word {valor=digit, erro=0}; an accepted unrecognised non-blank pattern SHALL produce {valor=4'hF, erro=1}.
REQ-020 Accepted words SHALL enter a 2-entry FIFO; valido = FIFO not empty; valor and erro show the FIFO head.
REQ-021 A transfer occurs on a rising edge with valido=1 and pronto=1; the head is popped on that edge.
REQ-022 While valido=1 and pronto=0, valor and erro SHALL hold stable.
REQ-023 A push and a pop on the same edge with the FIFO full SHALL both succeed, and the FIFO SHALL remain full.
REQ-024 A push into a full FIFO with no pop SHALL drop the new word, leave the FIFO contents unchanged, and set sobrecarga=1 until reset.
REQ-025 Latency with an empty FIFO: for a pattern first sampled on edge E1 and held, valido SHALL be 1 after edge E1+ESTAVEL (with ESTAVEL=4, after the 5th edge).
REQ-026 A glitch of one cycle SHALL restart counting; a pattern held for only ESTAVEL-1 samples SHALL never be accepted.

Reset
REQ-027 While reset=0, the block SHALL hold: valido=0, valor=0, erro=0, sobrecarga=0, FIFO empty, counter=0, FSM=OCIOSO, sample register=1111111.
REQ-028 Reset asserted mid-stabilisation or with words buffered SHALL discard all of them.
REQ-029 After reset is released, the first edge SHALL sample normally.

Verification
REQ-030 Hold 0010010 with ativo=1 and pronto=1, ESTAVEL=4 -> valido=1, valor=2, erro=0 after the 5th edge; exactly one transfer occurs; no second word is produced while the pattern is held.
REQ-031 Apply 0000110 for 3 cycles, then 0100100 held -> no word for 3; a single word valor=5 is produced.
REQ-032 Apply 1111110, blank, then 1111110 again, each held for 6 cycles -> two words, each valor=10.
REQ-033 Apply 0110110 held -> one word with valor=15, erro=1.
REQ-034 With pronto=0, accept digits 1, 3, 7 in sequence -> the FIFO holds 1 and 3, 7 is dropped, and sobrecarga=1; raising pronto yields 1 then 3, with valor stable while stalled.
REQ-035 Pull reset low at counter=3 with one word buffered -> all outputs are 0 immediately; after release, the held pattern needs a full ESTAVEL samples before it is accepted.

Source files
------------

// File: rtl/display_leitor.sv
// display_leitor: reads a seven-segment bus, debounces it, decodes the digit and buffers words in a 2-entry FIFO
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   segmentos  in   [6:0] active-low segments, bit 6 = a ... bit 0 = g
//   ativo      in   display enable; 0 forces a blank sample
//   pronto     in   downstream ready
//   valido     out  FIFO head available
//   valor      out  [3:0] head digit (0..10, 15 for unrecognised)
//   erro       out  head came from an unrecognised pattern
//   sobrecarga out  sticky: an accepted word was dropped on a full FIFO
module display_leitor #(
    parameter int ESTAVEL = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] segmentos,
    input  logic       ativo,
    input  logic       pronto,
    output logic       valido,
    output logic [3:0] valor,
    output logic       erro,
    output logic       sobrecarga
);
    typedef enum logic [1:0] {OCIOSO, ESTABILIZANDO, EMITIDO} estado_t;
    localparam logic [6:0] BRANCO = 7'h7F;
    estado_t estado, prox;
    logic [6:0] amostra, anterior;
    logic [3:0] cont, cont_prox;
    logic       aceitar, vazio, difere;
    logic [4:0] palavra, cabeca, cauda;
    logic [1:0] ocup;
    logic       pop, grava, idx;
    // palavra = {erro, valor}
    always_comb begin
        palavra = 5'h1F;
        case (amostra)
            7'b0000001: palavra = 5'h00;
            7'b1001111: palavra = 5'h01;
            7'b0010010: palavra = 5'h02;
            7'b0000110: palavra = 5'h03;
            7'b1001100: palavra = 5'h04;
            7'b0100100: palavra = 5'h05;
            7'b0100000: palavra = 5'h06;
            7'b0001101: palavra = 5'h07;
            7'b0000000: palavra = 5'h08;
            7'b0000100: palavra = 5'h09;
            7'b1111110: palavra = 5'h0A;
            default: ;
        endcase
    end
    always_comb begin
        prox      = estado;
        cont_prox = cont;
        aceitar   = 1'b0;
        vazio     = amostra == BRANCO;
        difere    = amostra != anterior;
        if (difere) cont_prox = 4'd1;
        else if (estado == ESTABILIZANDO) cont_prox = cont + 4'd1;
        if (vazio) prox = OCIOSO;
        else if (estado == OCIOSO || difere) prox = ESTABILIZANDO;
        else if (estado == ESTABILIZANDO && cont_prox == 4'(ESTAVEL)) begin
            prox    = EMITIDO;
            aceitar = 1'b1;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            cont     <= 4'd0;
            amostra  <= BRANCO;
            anterior <= BRANCO;
        end else begin
            estado   <= prox;
            cont     <= cont_prox;
            amostra  <= ativo ? segmentos : BRANCO;
            anterior <= amostra;
        end
    end
    // Shift-style FIFO: cabeca is always the head; a full FIFO still takes a push when it pops.
    assign valido = ocup != 2'd0;
    assign valor  = cabeca[3:0];
    assign erro   = cabeca[4];
    assign pop    = valido & pronto;
    assign grava  = aceitar & (ocup != 2'd2 | pop);
    assign idx    = ocup[1] | (ocup[0] & ~pop);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cabeca     <= 5'd0;
            cauda      <= 5'd0;
            ocup       <= 2'd0;
            sobrecarga <= 1'b0;
        end else begin
            if (pop) cabeca <= cauda;
            if (grava && !idx) cabeca <= palavra;
            if (grava && idx) cauda <= palavra;
            ocup       <= ocup + {1'b0, grava} - {1'b0, pop};
            sobrecarga <= sobrecarga | (aceitar & ocup == 2'd2 & ~pop);
        end
    end
endmodule

// File: tb/tb_display_leitor.sv
// tb_display_leitor: directed self-checking bench for display_leitor
module tb_display_leitor;
    localparam logic [6:0] BR = 7'b1111111, D1 = 7'b1001111, D2 = 7'b0010010, D3 = 7'b0000110,
                           D4 = 7'b1001100, D5 = 7'b0100100, D6 = 7'b0100000, D7 = 7'b0001101,
                           D8 = 7'b0000000, D9 = 7'b0000100, MENOS = 7'b1111110, RUIM = 7'b0110110;
    logic       clock = 1'b0, reset, ativo, pronto, valido, erro, sobrecarga;
    logic [6:0] segmentos;
    logic [3:0] valor;
    logic [4:0] rec[$];
    int         comparados = 0, divergentes = 0;

    display_leitor #(.ESTAVEL(4)) dut (
        .clock(clock), .reset(reset), .segmentos(segmentos), .ativo(ativo), .pronto(pronto),
        .valido(valido), .valor(valor), .erro(erro), .sobrecarga(sobrecarga)
    );

    always #5 clock = ~clock;

    // A transfer happens on the next rising edge whenever valido and pronto are both high mid-cycle.
    always @(negedge clock) if (reset && valido && pronto) rec.push_back({erro, valor});

    task automatic confere(input string tag, input logic [7:0] obs, input logic [7:0] esp);
        comparados++;
        if (obs !== esp) begin
            divergentes++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic aplica(input logic [6:0] p, input int n);
        segmentos = p;
        ciclos(n);
    endtask

    function automatic logic [7:0] pega(input int i);
        return (i < rec.size()) ? {3'b000, rec[i]} : 8'hEE;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ativo = 1'b1; pronto = 1'b1; segmentos = D8;
        ciclos(6);
        confere("rst_valido", 8'(valido), 8'h0);
        confere("rst_valor", 8'(valor), 8'h0);
        confere("rst_erro", 8'(erro), 8'h0);
        confere("rst_sobre", 8'(sobrecarga), 8'h0);
        segmentos = BR; reset = 1'b1;
        ciclos(2);
        // digit 2 held: latency of 5 edges, exactly one word
        segmentos = D2;
        ciclos(4);
        confere("lat4_valido", 8'(valido), 8'h0);
        ciclos(1);
        confere("lat5_valido", 8'(valido), 8'h1);
        confere("lat5_valor", 8'(valor), 8'h2);
        confere("lat5_erro", 8'(erro), 8'h0);
        ciclos(10);
        confere("d2_words", 8'(rec.size()), 8'd1);
        confere("d2_word", pega(0), 8'h02);
        aplica(BR, 3); rec.delete();
        // 3 held for only 3 samples, then 5
        aplica(D3, 3); aplica(D5, 12);
        confere("d35_words", 8'(rec.size()), 8'd1);
        confere("d35_word", pega(0), 8'h05);
        aplica(BR, 3); rec.delete();
        // minus, blank, minus
        aplica(MENOS, 6); aplica(BR, 6); aplica(MENOS, 6); aplica(BR, 4);
        confere("menos_words", 8'(rec.size()), 8'd2);
        confere("menos_w0", pega(0), 8'h0A);
        confere("menos_w1", pega(1), 8'h0A);
        rec.delete();
        // unrecognised pattern
        aplica(RUIM, 8); aplica(BR, 3);
        confere("ruim_words", 8'(rec.size()), 8'd1);
        confere("ruim_word", pega(0), 8'h1F);
        rec.delete();
        // glitch and ativo=0 produce nothing
        aplica(D1, 3); aplica(D8, 1); aplica(D1, 3); aplica(BR, 3);
        ativo = 1'b0; aplica(D5, 8); ativo = 1'b1; aplica(BR, 3);
        confere("glitch_words", 8'(rec.size()), 8'd0);
        // stalled: 1, 3 buffered, 7 dropped
        pronto = 1'b0;
        aplica(D1, 6); aplica(D3, 6); aplica(D7, 6);
        confere("ovf_valido", 8'(valido), 8'h1);
        confere("ovf_valor", 8'(valor), 8'h1);
        confere("ovf_sobre", 8'(sobrecarga), 8'h1);
        ciclos(3);
        confere("stall_valor", 8'(valor), 8'h1);
        segmentos = BR; pronto = 1'b1;
        ciclos(1);
        confere("pop1_valor", 8'(valor), 8'h3);
        confere("pop1_valido", 8'(valido), 8'h1);
        ciclos(1);
        confere("pop2_valido", 8'(valido), 8'h0);
        confere("ovf_words", 8'(rec.size()), 8'd2);
        confere("ovf_w0", pega(0), 8'h01);
        confere("ovf_w1", pega(1), 8'h03);
        confere("ovf_sticky", 8'(sobrecarga), 8'h1);
        rec.delete();
        // reset mid-stabilisation with one word buffered
        pronto = 1'b0;
        aplica(D2, 6);
        confere("pre_rst_valor", 8'(valor), 8'h2);
        segmentos = D8;
        ciclos(4);
        reset = 1'b0;
        #1;
        confere("arst_valido", 8'(valido), 8'h0);
        confere("arst_valor", 8'(valor), 8'h0);
        confere("arst_sobre", 8'(sobrecarga), 8'h0);
        ciclos(1);
        reset = 1'b1;
        ciclos(4);
        confere("post_rst4", 8'(valido), 8'h0);
        ciclos(1);
        confere("post_rst5", 8'(valido), 8'h1);
        confere("post_rst_valor", 8'(valor), 8'h8);
        pronto = 1'b1; aplica(BR, 3);
        confere("post_rst_words", 8'(rec.size()), 8'd1);
        rec.delete();
        // push and pop on the same edge while full
        pronto = 1'b0;
        aplica(D4, 6); aplica(D6, 6);
        confere("full_valor", 8'(valor), 8'h4);
        segmentos = D9;
        ciclos(4);
        pronto = 1'b1;
        ciclos(1);
        confere("pp_valor", 8'(valor), 8'h6);
        confere("pp_sobre", 8'(sobrecarga), 8'h0);
        ciclos(1);
        confere("pp_next", 8'(valor), 8'h9);
        ciclos(1);
        confere("pp_empty", 8'(valido), 8'h0);
        aplica(BR, 3);
        confere("pp_words", 8'(rec.size()), 8'd3);
        confere("pp_w2", pega(2), 8'h09);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, divergentes);
        $finish;
    end
endmodule
